// File: rtl/md5_search_pkg.sv
// Shared widths, FSM encoding and match-entry layout for the MD5 search datapath.
package md5_search_pkg;

  localparam int HASH_W    = 128;
  localparam int MSG_W     = 448;
  localparam int LEN_W     = 64;
  localparam int CNT_W_DEF = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MSG_W-1:0]     message;
    logic [LEN_W-1:0]     len;
    logic [CNT_W_DEF-1:0] index;
  } match_entry_t;

  function automatic int entry_w(input int cnt_w);
    return MSG_W + LEN_W + cnt_w;
  endfunction

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head, occupancy count
// and full/empty flags. A synchronous clear empties it without touching storage.
module match_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic          w_pop;
  logic          w_push;
  logic [PW-1:0] w_rd_nxt;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_pop    = i_rd_en && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push   = i_wr_en && (!o_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + PW'(1);

  // NOTE: storage has no reset; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head mirrors r_mem[r_rd_ptr]; on an empty or draining FIFO it bypasses the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (!i_clear) begin
      if (w_push && (o_empty || (w_pop && r_count == ONE_CNT)))
        r_head <= i_wr_data;
      else if (w_pop && r_count > ONE_CNT)
        r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_rd_data = r_head;
  assign o_count   = r_count;

endmodule

// File: rtl/hash_match_collector.sv
// Compares md5core digests against a programmed goal and queues matching candidates.
// Optional HASH_MASK_EN adds a programmable compare mask for partial-digest matches.
module hash_match_collector
  import md5_search_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 48,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_program,
  input  logic [HASH_W-1:0] i_prg_h_goal,
`ifdef HASH_MASK_EN
  input  logic [HASH_W-1:0] i_prg_h_mask,
`endif
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_hash_valid,
  input  logic [HASH_W-1:0] i_hash,
  input  logic [MSG_W-1:0]  i_message_in,
  input  logic [LEN_W-1:0]  i_msg_len,
  output logic              o_match_valid,
  input  logic              i_match_ready,
  output logic [MSG_W-1:0]  o_match_message,
  output logic [LEN_W-1:0]  o_match_len,
  output logic [CNT_W-1:0]  o_match_index,
  output logic [CNT_W-1:0]  o_tested_count,
  output logic [CW-1:0]     o_fifo_count,
  output logic              o_overflow,
  output logic [1:0]        o_state
);

  typedef struct packed {
    logic [MSG_W-1:0] message;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] index;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HASH_W-1:0] r_goal;
  logic [CNT_W-1:0]  r_tested;
  logic              r_s1_valid;
  logic              r_s1_hit;
  entry_t            r_s1_entry;
  logic              r_overflow;

  logic   w_accept;
  logic   w_hit;
  logic   w_push;
  logic   w_full;
  logic   w_empty;
  entry_t w_head;

`ifdef HASH_MASK_EN
  logic [HASH_W-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_mask <= '1;
    else if (i_program) r_mask <= i_prg_h_mask;
  end

  assign w_hit = (((i_hash ^ r_goal) & r_mask) == '0);
`else
  assign w_hit = (i_hash == r_goal);
`endif

  assign w_accept = (r_state == ST_ARMED) && i_hash_valid && !i_program;
  // abort/program in the cycle a hit sits in stage 1 discard it.
  assign w_push   = r_s1_valid && r_s1_hit && !i_abort && !i_program;

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    w_state_nxt = r_state;
    if (i_program) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (i_start && !i_abort) w_state_nxt = ST_ARMED;
        ST_ARMED: if (i_abort)             w_state_nxt = ST_DONE;
        ST_DONE:  if (i_start && !i_abort) w_state_nxt = ST_ARMED;
        default:                           w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_goal     <= '0;
      r_tested   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_program) begin
      r_state    <= ST_IDLE;
      r_goal     <= i_prg_h_goal;
      r_tested   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s1_valid <= w_accept && !i_abort;
      if (w_accept) begin
        r_s1_hit <= w_hit;
        if (r_tested != '1) r_tested <= r_tested + CNT_W'(1);
      end
      if (w_push && w_full && !i_match_ready) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_entry.message <= i_message_in;
      r_s1_entry.len     <= i_msg_len;
      r_s1_entry.index   <= r_tested;
    end
  end

  match_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (i_program),
    .i_wr_en   (w_push),
    .i_wr_data (r_s1_entry),
    .i_rd_en   (i_match_ready),
    .o_rd_data (w_head),
    .o_count   (o_fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_match_valid   = !w_empty;
  assign o_match_message = w_head.message;
  assign o_match_len     = w_head.len;
  assign o_match_index   = w_head.index;
  assign o_tested_count  = r_tested;
  assign o_overflow      = r_overflow;
  assign o_state         = r_state;

endmodule

// File: doc/hash_match_collector.md
Name: hash_match_collector

Overview:
- Downstream of md5core; consumes each candidate's 128-bit hash together with the 448-bit message and 64-bit length that produced it.
- Compares every hash against a programmed goal digest.
- Queues matching candidates in a small FIFO and drains them through a valid/ready port to the host/readout logic.
- Keeps a running count of candidates tested so search throughput and match positions can be reported.

Parameters:
- DEPTH, 4, number of match entries buffered (power of two, ≥2).
- CNT_W, 48, width of the tested-candidate counter and match index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- program  in  1  load goal; clear FIFO, counters, overflow; go to IDLE.
- prg_h_goal  in  128  goal digest, sampled when program=1.
- start  in  1  arm the search.
- abort  in  1  stop the search.
- hash_valid  in  1  hash/message_in/msg_len valid this cycle.
- hash  in  128  md5core digest.
- message_in  in  448  candidate message aligned with hash.
- msg_len  in  64  candidate length aligned with hash.
- match_valid  out  1  FIFO head valid.
- match_ready  in  1  consumer accepts head.
- match_message  out  448  head message.
- match_len  out  64  head length.
- match_index  out  CNT_W  tested_count value at the candidate's arrival (0-based).
- tested_count  out  CNT_W  candidates compared while ARMED.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- overflow  out  1  sticky: a match was dropped.
- state  out  2  IDLE=0, ARMED=1, DONE=2.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; goal=0; FIFO empty; match_valid=0; match_message/len/index=0; tested_count=0; fifo_count=0; overflow=0; compare stage invalid.
- State machine:
  - IDLE: start → ARMED.
  - ARMED: abort → DONE.
  - DONE: start → ARMED, counters retained.
  - program in any state → IDLE with full clear, and overrides start/abort in the same cycle.
  - abort has priority over start.
- Only while ARMED (registered state) is hash_valid accepted. In IDLE and DONE it is ignored and not counted.
- Stage 1, edge ending cycle N with hash_valid=1:
  - register hit = (hash == goal), plus message_in, msg_len, index = tested_count.
  - tested_count increments, saturating at all-ones.
- Stage 2, edge ending cycle N+1: if hit, push the entry. match_valid rises in cycle N+2 when the FIFO was empty.
- Accepted hashes arrive back-to-back at one per cycle with no stall. The block never backpressures md5core.
- abort or program flushes stage 1: an in-flight hit is not pushed. Entries already in the FIFO remain after abort but are cleared by program.
- Pop occurs when match_valid and match_ready. The head is a registered FWFT output; the next entry appears the cycle after the pop.
- Full FIFO:
  - a push with no simultaneous pop is dropped and sets overflow (sticky until program/reset).
  - push plus pop in the same cycle is accepted and occupancy is unchanged.
- Empty FIFO: match_ready is ignored; match_valid=0 and head fields hold their last value.
- Pointers are log2(DEPTH)-bit and wrap; fifo_count is kept separately.
- rst_n mid-search: everything returns to reset values the next edge and in-flight data is lost.

Optional Feature:
- HASH_MASK_EN defined:
  - adds input prg_h_mask[127:0], sampled with program; reset value is all-ones.
  - hit = ((hash ^ goal) & mask) == 0, which allows partial-digest matches for bring-up.
  - mask=0 matches every candidate.
- Undefined: no prg_h_mask port; exact 128-bit compare.

Decomposition:
- Shared package md5_search_pkg:
  - widths: HASH_W=128, MSG_W=448, LEN_W=64.
  - state encodings: IDLE/ARMED/DONE.
  - match-entry struct {message, len, index}.
- Sub-module match_fifo: parameterised DEPTH/width sync FIFO with FWFT registered head, count, full/empty. The top handles compare, counting, FSM, and overflow policy.

Test Plan:
- Reset, then program goal=H; start; feed 10 hashes with H at position 6 → tested_count=10; single entry with match_index=6 and the correct message/len; match_valid rises 2 cycles after the hit input.
- Feed H on 6 consecutive cycles with match_ready=0 and DEPTH=4 → fifo_count=4, overflow=1; then drain 4 entries with indices in order; a further program clears overflow.
- FIFO full with match_ready=1 and a new hit in the same cycle → push accepted, fifo_count stays 4, overflow=0.
- Hit on cycle N, abort on cycle N+1 → state=DONE, hit not pushed; later hash_valid is not counted.
- program asserted concurrently with start while ARMED holding 2 entries → state=IDLE, FIFO empty, tested_count=0.
- HASH_MASK_EN with mask=upper 32 bits set → hash matching only the top 32 bits of goal is captured; hash differing in bit 127 is not.
